pzbcm_rr_arbiter: RTL and testbench
===================================

PZBCM_RR_ARBITER -- requirements
Module: pzbcm_rr_arbiter

Interface
REQ-001 SHALL have parameter REQUESTS, default 2, meaning the number of requesters, legal range 1..64.
REQ-002 SHALL have localparam INDEX_WIDTH, equal to (REQUESTS >= 2) ? $clog2(REQUESTS) : 1, meaning the width of the grant index.
REQ-003 SHALL have port i_clk, input, 1 bit: the single clock; all state is rising-edge.
REQ-004 SHALL have port i_rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port i_request, input, REQUESTS bits: per-requester request level.
REQ-006 SHALL have port i_free, input, 1 bit: the current owner releases the resource.
REQ-007 SHALL have port o_busy, output, 1 bit: a grant is held.
REQ-008 SHALL have port o_grant, output, REQUESTS bits: one-hot grant, registered.
REQ-009 SHALL have port o_grant_index, output, INDEX_WIDTH bits: binary index of o_grant, registered.

Function
REQ-010 SHALL implement a two-state FSM: IDLE (no owner) and BUSY (grant held).
REQ-011 SHALL pick a winner by masked round-robin on each arbitration.
- Masked candidates: i_request bits with index strictly greater than pointer ptr.
- If any masked candidate exists, the winner is its lowest set bit; otherwise the winner is the lowest set bit of i_request.
REQ-012 IDLE with |i_request=1 SHALL register the winner into o_grant/o_grant_index, set o_busy, and go to BUSY; grant is visible 1 cycle after request.
REQ-013 IDLE with i_request=0 SHALL remain IDLE with o_grant=0.
REQ-014 BUSY SHALL hold o_grant, o_grant_index and o_busy constant regardless of i_request, including deassertion by the owner, until i_free=1.
REQ-015 BUSY with i_free=1 SHALL load ptr with o_grant_index in the same edge.
REQ-016 BUSY with i_free=1 SHALL re-arbitrate in the same cycle using the updated-pointer rule, i.e. with the mask taken relative to the releasing index.
- If any request remains, SHALL load the new winner and stay BUSY (zero-bubble hand-off).
- Otherwise SHALL clear o_grant, o_busy and o_grant_index to 0 and go to IDLE.
REQ-017 The releasing owner SHALL be eligible in that same re-arbitration only if no other requester is active.
REQ-018 i_free in IDLE SHALL be ignored and SHALL NOT change ptr.
REQ-019 ptr SHALL be INDEX_WIDTH bits; the mask compare SHALL wrap so that ptr=REQUESTS-1 yields an empty mask, selecting the lowest set bit overall.
REQ-020 o_grant SHALL be zero or exactly one-hot, and SHALL always be a subset of the i_request value sampled at arbitration.
REQ-021 REQUESTS=1: o_grant SHALL follow the same FSM, o_grant_index SHALL be tied to 0, and ptr SHALL be unused.

Reset
REQ-022 Asserting i_rst_n=0 at any time, including mid-BUSY, SHALL immediately set state=IDLE, o_grant=0, o_grant_index=0, o_busy=0 and ptr=REQUESTS-1, so that requester 0 has highest priority first.
REQ-023 After deassertion, the first arbitration SHALL occur no earlier than the first rising edge with i_rst_n=1.

Structure
REQ-024 SHALL place the state enum (IDLE, BUSY) in package pzbcm_rr_arbiter_pkg.
REQ-025 SHALL instantiate the pzbcm_onehot interface (N=REQUESTS) as its one helper.
- to_onehot SHALL perform lowest-set-bit selection on both the masked and unmasked vectors.
- to_binary SHALL produce o_grant_index.
- No other sub-module.
REQ-026 The combinational pick path SHALL be pure; all outputs SHALL come directly from flops.

Verification (REQUESTS=4)
REQ-027 SHALL cover the post-reset pick: i_request=4'b1111 -> next cycle o_grant=4'b0001, o_grant_index=0, o_busy=1.
REQ-028 SHALL cover rotation: hold 4'b1111 and pulse i_free for 1 cycle every 3 cycles -> grants 0001, 0010, 0100, 1000, 0001 in sequence, each held until i_free, with no idle cycle between.
REQ-029 SHALL cover hold: owner 0010 drops its request while i_free=0 for 5 cycles -> o_grant stays 0010; then i_free=1 with i_request=0 -> next cycle o_grant=0 and o_busy=0.
REQ-030 SHALL cover wrap: owner index 3 frees while i_request=4'b1001 -> next grant 0001, not 1000.
REQ-031 SHALL cover reset mid-BUSY: assert i_rst_n=0 while o_grant=0100 -> outputs 0 without waiting for a clock edge; after release, i_request=4'b0110 -> grant 0010.
REQ-032 SHALL cover the ignored i_free: i_free=1 in IDLE with ptr=1, then i_request=4'b0011 -> grant 0001, confirming ptr was not disturbed.

Source files
------------

// File: rtl/pzbcm_rr_arbiter_pkg.sv
// Shared types for the round-robin arbiter.
// Holds the arbiter FSM state encoding.
package pzbcm_rr_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } rr_state_e;

endpackage

// File: rtl/pzbcm_onehot.sv
// One-hot helpers: lowest-set-bit pick and
// one-hot to binary index conversion.
interface pzbcm_onehot #(
  parameter int N = 2
);

  localparam int W = (N >= 2) ? $clog2(N) : 1;

  function automatic logic [N-1:0] to_onehot(
    input logic [N-1:0] bits
  );
    return bits & (~bits + N'(1));
  endfunction

  function automatic logic [W-1:0] to_binary(
    input logic [N-1:0] onehot
  );
    logic [W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (onehot[i]) begin
        idx = idx | W'(i);
      end
    end
    return idx;
  endfunction

endinterface

// File: rtl/pzbcm_rr_arbiter.sv
// Masked round-robin arbiter with registered
// one-hot grant and zero-bubble hand-off.
module pzbcm_rr_arbiter
  import pzbcm_rr_arbiter_pkg::*;
#(
  parameter int REQUESTS = 2,
  localparam int INDEX_WIDTH =
    (REQUESTS >= 2) ? $clog2(REQUESTS) : 1
)(
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [REQUESTS-1:0]    i_request,
  input  logic                   i_free,
  output logic                   o_busy,
  output logic [REQUESTS-1:0]    o_grant,
  output logic [INDEX_WIDTH-1:0] o_grant_index
);

  localparam logic [INDEX_WIDTH-1:0] PTR_INIT =
    INDEX_WIDTH'(REQUESTS - 1);

  pzbcm_onehot #(.N(REQUESTS)) u_onehot ();

  rr_state_e              state;
  rr_state_e              state_next;
  logic [INDEX_WIDTH-1:0] ptr;
  logic [INDEX_WIDTH-1:0] ptr_next;
  logic [INDEX_WIDTH-1:0] pick_ptr;
  logic [REQUESTS-1:0]    mask;
  logic [REQUESTS-1:0]    masked;
  logic [REQUESTS-1:0]    win;
  logic [INDEX_WIDTH-1:0] win_index;
  logic [REQUESTS-1:0]    grant_next;
  logic [INDEX_WIDTH-1:0] index_next;
  logic                   busy_next;

  // Winner pick; on release the mask is relative
  // to the releasing owner, not the stored ptr.
  always_comb begin
    pick_ptr = ptr;
    if (state == BUSY && i_free) begin
      pick_ptr = o_grant_index;
    end
    mask = '0;
    for (int i = 0; i < REQUESTS; i++) begin
      mask[i] = 32'(i) > 32'(pick_ptr);
    end
    masked = i_request & mask;
    if (|masked) begin
      win = u_onehot.to_onehot(masked);
    end else begin
      win = u_onehot.to_onehot(i_request);
    end
    if (REQUESTS == 1) begin
      win_index = '0;
    end else begin
      win_index = u_onehot.to_binary(win);
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    grant_next = o_grant;
    index_next = o_grant_index;
    busy_next  = o_busy;
    unique case (state)
      IDLE: begin
        if (|i_request) begin
          grant_next = win;
          index_next = win_index;
          busy_next  = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (i_free) begin
          ptr_next = o_grant_index;
          if (|i_request) begin
            grant_next = win;
            index_next = win_index;
          end else begin
            grant_next = '0;
            index_next = '0;
            busy_next  = 1'b0;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, pointer and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= IDLE;
      ptr           <= PTR_INIT;
      o_grant       <= '0;
      o_grant_index <= '0;
      o_busy        <= 1'b0;
    end else begin
      state         <= state_next;
      ptr           <= ptr_next;
      o_grant       <= grant_next;
      o_grant_index <= index_next;
      o_busy        <= busy_next;
    end
  end

endmodule

// File: tb/tb_pzbcm_rr_arbiter.sv
// Directed bench for pzbcm_rr_arbiter with
// REQUESTS=4 and hand-computed grants.
module tb_pzbcm_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       free;
  logic       busy;
  logic [3:0] grant;
  logic [1:0] gidx;

  int checks;
  int errors;

  pzbcm_rr_arbiter #(.REQUESTS(4)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_request    (req),
    .i_free       (free),
    .o_busy       (busy),
    .o_grant      (grant),
    .o_grant_index(gidx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(
    input string      tag,
    input logic [3:0] g,
    input logic [1:0] ix,
    input logic       b
  );
    check({tag, ".grant"}, 32'(grant), 32'(g));
    check({tag, ".index"}, 32'(gidx), 32'(ix));
    check({tag, ".busy"}, 32'(busy), 32'(b));
  endtask

  logic [3:0] rot_g [4];
  logic [1:0] rot_i [4];

  initial begin
    checks = 0;
    errors = 0;
    rot_g = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rot_i = '{2'd1, 2'd2, 2'd3, 2'd0};
    rst_n = 1'b0;
    req   = '0;
    free  = 1'b0;
    #3;
    expect_out("reset", 4'b0000, 2'd0, 1'b0);
    step();
    rst_n = 1'b1;
    step();
    expect_out("idle_noreq", 4'b0000, 2'd0, 1'b0);

    req = 4'b1111;
    step();
    expect_out("first_pick", 4'b0001, 2'd0, 1'b1);

    for (int k = 0; k < 4; k++) begin
      step();
      expect_out("rot_hold", grant, 2'(gidx), 1'b1);
      check("rot_hold_g", 32'(grant),
            32'(k == 0 ? 4'b0001 : rot_g[k-1]));
      step();
      free = 1'b1;
      step();
      free = 1'b0;
      expect_out("rotate", rot_g[k], rot_i[k], 1'b1);
    end

    free = 1'b1;
    step();
    free = 1'b0;
    expect_out("to_0010", 4'b0010, 2'd1, 1'b1);
    req = 4'b0000;
    for (int k = 0; k < 5; k++) begin
      step();
      expect_out("hold", 4'b0010, 2'd1, 1'b1);
    end
    free = 1'b1;
    step();
    free = 1'b0;
    expect_out("release_idle", 4'b0000, 2'd0, 1'b0);

    free = 1'b1;
    step();
    step();
    free = 1'b0;
    expect_out("free_in_idle", 4'b0000, 2'd0, 1'b0);
    req = 4'b0011;
    step();
    expect_out("ptr_kept", 4'b0001, 2'd0, 1'b1);

    req  = 4'b1000;
    free = 1'b1;
    step();
    expect_out("to_idx3", 4'b1000, 2'd3, 1'b1);
    req = 4'b1001;
    step();
    expect_out("wrap", 4'b0001, 2'd0, 1'b1);

    req = 4'b0001;
    step();
    expect_out("self_regrant", 4'b0001, 2'd0, 1'b1);
    req = 4'b0100;
    step();
    free = 1'b0;
    expect_out("to_0100", 4'b0100, 2'd2, 1'b1);

    #2;
    rst_n = 1'b0;
    #1;
    expect_out("async_rst", 4'b0000, 2'd0, 1'b0);
    step();
    expect_out("in_rst", 4'b0000, 2'd0, 1'b0);
    req   = 4'b0110;
    rst_n = 1'b1;
    step();
    expect_out("post_rst", 4'b0010, 2'd1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
